// File: rtl/logic_eval_arbiter_if.sv
// Requester-side handshake bundle for logic_eval_arbiter.
// master = requester/testbench side, slave = arbiter side.
interface logic_eval_arbiter_if #(
  parameter int CNT_W = 8
);
  logic             REQ0, REQ1;
  logic [4:0]       DIN0, DIN1;
  logic             ACK0, ACK1;
  logic             GNT0, GNT1;
  logic             VLD;
  logic             OWNER;
  logic [2:0]       DOUT;
  logic             BUSY;
  logic             TOUT;
  logic [CNT_W-1:0] CNT0, CNT1;

  modport master (
    output REQ0, REQ1, DIN0, DIN1, ACK0, ACK1,
    input  GNT0, GNT1, VLD, OWNER, DOUT, BUSY, TOUT, CNT0, CNT1
  );

  modport slave (
    input  REQ0, REQ1, DIN0, DIN1, ACK0, ACK1,
    output GNT0, GNT1, VLD, OWNER, DOUT, BUSY, TOUT, CNT0, CNT1
  );
endinterface

// File: rtl/logic_eval_arbiter.sv
// Two-requester round-robin arbiter around a small combinational logic
// evaluator. One transaction in flight: IDLE -> EVAL -> RESP -> IDLE,
// with an ACK timeout in RESP and per-requester completion counters.
module logic_eval_arbiter #(
  parameter int TO_CYC = 15,
  parameter int CNT_W  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  logic_eval_arbiter_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // last RESP cycle index before the timeout fires
  localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);

  logic [1:0]       state;
  logic [4:0]       opnd;
  logic             owner, last, vld, tout, gnt0, gnt1;
  logic [2:0]       dout;
  logic [7:0]       to_cnt;
  logic [CNT_W-1:0] cnt0, cnt1;

  logic             win, ack_own, to_hit;
  logic [2:0]       fres;

  // Arbitration winner, owner's ACK, timeout expiry and the evaluator.
  always_comb begin
    win     = (bus.REQ0 & bus.REQ1) ? ~last : bus.REQ1;
    ack_own = owner ? bus.ACK1 : bus.ACK0;
    to_hit  = (to_cnt == TO_LAST);
    // opnd[0..4] = A..E; fres = {F3, F2, F1}
    fres[0] = ~(~(opnd[0] | opnd[1]) & opnd[2]);
    fres[1] = ~(opnd[1] & opnd[2]);
    fres[2] = ~opnd[3] | opnd[2] | opnd[4];
  end

  // Transaction FSM: capture on grant, evaluate on the edge after the grant
  // pulse, then hold the result until the owner ACKs or the timeout expires.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= S_IDLE;
      opnd   <= '0;
      owner  <= 1'b0;
      last   <= 1'b1;   // "last served = 1" gives requester 0 priority
      vld    <= 1'b0;
      tout   <= 1'b0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      dout   <= '0;
      to_cnt <= '0;
      cnt0   <= '0;
      cnt1   <= '0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      tout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.REQ0 | bus.REQ1) begin
            opnd  <= win ? bus.DIN1 : bus.DIN0;
            owner <= win;
            gnt0  <= ~win;
            gnt1  <= win;
            state <= S_EVAL;
          end
        end
        S_EVAL: begin
          // the grant cycle is spent in EVAL; the result is registered once
          // the grant pulse has gone, so VLD rises two edges after the grant
          if (!(gnt0 | gnt1)) begin
            dout   <= fres;
            vld    <= 1'b1;
            to_cnt <= '0;
            state  <= S_RESP;
          end
        end
        S_RESP: begin
          if (ack_own) begin
            // ACK wins over a coincident timeout
            vld   <= 1'b0;
            last  <= owner;
            state <= S_IDLE;
            if (owner) cnt1 <= cnt1 + 1'b1;
            else       cnt0 <= cnt0 + 1'b1;
          end else if (to_hit) begin
            vld   <= 1'b0;
            tout  <= 1'b1;
            last  <= owner;
            state <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.GNT0  = gnt0;
  assign bus.GNT1  = gnt1;
  assign bus.VLD   = vld;
  assign bus.OWNER = owner;
  assign bus.DOUT  = dout;
  assign bus.BUSY  = (state != S_IDLE);
  assign bus.TOUT  = tout;
  assign bus.CNT0  = cnt0;
  assign bus.CNT1  = cnt1;

endmodule

// File: tb/tb_logic_eval_arbiter.sv
// Directed bench for logic_eval_arbiter: a per-cycle vector table for the
// single-request and contention flows, then hand sequences for timeout,
// non-owner ACK, ACK-at-expiry, async reset and counter wrap.
module tb_logic_eval_arbiter;

  localparam int CW = 2;

  logic CLK, RST;
  int   n_vec = 0;
  int   n_bad = 0;

  logic_eval_arbiter_if #(.CNT_W(CW)) bus ();

  logic_eval_arbiter #(.TO_CYC(15), .CNT_W(CW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst_n, req0, req1;
    logic [4:0]  din0, din1;
    logic        ack0, ack1;
    logic [12:0] exp;
  } vec_t;

  vec_t tv[$];

  localparam logic [4:0] DA = 5'b00100;  // C only  -> 110
  localparam logic [4:0] DB = 5'b01000;  // D only  -> 011
  localparam logic [4:0] DC = 5'b10111;  // A,B,C,E -> 101

  // {GNT0,GNT1,VLD,OWNER,DOUT,BUSY,TOUT,CNT0,CNT1}
  function automatic logic [12:0] o(logic g0, logic g1, logic v, logic ow,
                                    logic [2:0] d, logic b, logic t,
                                    logic [1:0] c0, logic [1:0] c1);
    return {g0, g1, v, ow, d, b, t, c0, c1};
  endfunction

  function automatic logic [12:0] obs();
    return {bus.GNT0, bus.GNT1, bus.VLD, bus.OWNER, bus.DOUT, bus.BUSY,
            bus.TOUT, bus.CNT0, bus.CNT1};
  endfunction

  function automatic vec_t mk(logic r, logic q0, logic q1, logic [4:0] d0,
                              logic [4:0] d1, logic a0, logic a1,
                              logic [12:0] e);
    vec_t v;
    v.rst_n = r; v.req0 = q0; v.req1 = q1; v.din0 = d0; v.din1 = d1;
    v.ack0 = a0; v.ack1 = a1; v.exp = e;
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle_in();
    bus.REQ0 = 0; bus.REQ1 = 0; bus.ACK0 = 0; bus.ACK1 = 0;
  endtask

  initial begin
    RST = 1'b0;
    idle_in();
    bus.DIN0 = '0; bus.DIN1 = '0;

    // single request, non-owner ACK ignored, owner ACK completes
    tv.push_back(mk(1,1,0,DA,0,0,0, o(1,0,0,0,3'b000,1,0,0,0)));
    tv.push_back(mk(1,0,0,DA,0,0,0, o(0,0,0,0,3'b000,1,0,0,0)));
    tv.push_back(mk(1,0,0,DA,0,0,0, o(0,0,1,0,3'b110,1,0,0,0)));
    tv.push_back(mk(1,0,0,DA,0,0,1, o(0,0,1,0,3'b110,1,0,0,0)));
    tv.push_back(mk(1,0,0,DA,0,1,0, o(0,0,0,0,3'b110,0,0,1,0)));
    tv.push_back(mk(0,0,0,0, 0,0,0, o(0,0,0,0,3'b000,0,0,0,0)));
    // contention with ACKs held high: 0,1,0,1, no grant on RESP exit edge
    tv.push_back(mk(1,1,1,DA,DB,1,1, o(1,0,0,0,3'b000,1,0,0,0)));
    tv.push_back(mk(1,1,1,DA,DB,1,1, o(0,0,0,0,3'b000,1,0,0,0)));
    tv.push_back(mk(1,1,1,DA,DB,1,1, o(0,0,1,0,3'b110,1,0,0,0)));
    tv.push_back(mk(1,1,1,DA,DB,1,1, o(0,0,0,0,3'b110,0,0,1,0)));
    tv.push_back(mk(1,1,1,DA,DB,1,1, o(0,1,0,1,3'b110,1,0,1,0)));
    tv.push_back(mk(1,1,1,DA,DB,1,1, o(0,0,0,1,3'b110,1,0,1,0)));
    tv.push_back(mk(1,1,1,DA,DB,1,1, o(0,0,1,1,3'b011,1,0,1,0)));
    tv.push_back(mk(1,1,1,DA,DB,1,1, o(0,0,0,1,3'b011,0,0,1,1)));
    tv.push_back(mk(1,1,1,DA,DB,1,1, o(1,0,0,0,3'b011,1,0,1,1)));
    tv.push_back(mk(1,1,1,DA,DB,1,1, o(0,0,0,0,3'b011,1,0,1,1)));
    tv.push_back(mk(1,1,1,DA,DB,1,1, o(0,0,1,0,3'b110,1,0,1,1)));
    tv.push_back(mk(1,1,1,DA,DB,1,1, o(0,0,0,0,3'b110,0,0,2,1)));
    tv.push_back(mk(1,1,1,DA,DB,1,1, o(0,1,0,1,3'b110,1,0,2,1)));
    tv.push_back(mk(1,1,1,DA,DB,1,1, o(0,0,0,1,3'b110,1,0,2,1)));
    tv.push_back(mk(1,1,1,DA,DB,1,1, o(0,0,1,1,3'b011,1,0,2,1)));
    tv.push_back(mk(1,1,1,DA,DB,1,1, o(0,0,0,1,3'b011,0,0,2,2)));
    tv.push_back(mk(1,0,0,0, 0, 0,0, o(0,0,0,1,3'b011,0,0,2,2)));

    #1 chk("reset_state", obs(), 0);
    @(negedge CLK);
    RST = 1'b1;

    foreach (tv[i]) begin
      RST = tv[i].rst_n;
      bus.REQ0 = tv[i].req0; bus.REQ1 = tv[i].req1;
      bus.DIN0 = tv[i].din0; bus.DIN1 = tv[i].din1;
      bus.ACK0 = tv[i].ack0; bus.ACK1 = tv[i].ack1;
      tick();
      chk($sformatf("vec%0d", i), obs(), tv[i].exp);
    end
    RST = 1'b1;

    // timeout: requester 1, never ACKed by owner (ACK0 toggling is ignored)
    bus.REQ1 = 1; bus.DIN1 = DB;
    tick(); chk("to_gnt1", {bus.GNT1, bus.GNT0}, 2'b10);
    bus.REQ1 = 0;
    tick(); tick();
    chk("to_vld_dout", {bus.VLD, bus.OWNER, bus.DOUT}, {2'b11, 3'b011});
    for (int i = 1; i < 15; i++) begin
      bus.ACK0 = i[0];
      tick();
      chk($sformatf("to_hold%0d", i), {bus.VLD, bus.TOUT}, 2'b10);
    end
    bus.ACK0 = 0;
    tick();
    chk("to_fire", {bus.TOUT, bus.VLD, bus.BUSY, bus.CNT0, bus.CNT1},
        {3'b100, 2'd2, 2'd2});
    tick();
    chk("to_pulse_end", {bus.TOUT, bus.BUSY}, 2'b00);

    // async reset in EVAL with requester 1 owning
    bus.REQ1 = 1; bus.DIN1 = DB;
    tick(); chk("ar_gnt", {bus.GNT1, bus.BUSY, bus.OWNER}, 3'b111);
    bus.REQ1 = 0;
    #2 RST = 1'b0;
    #1 chk("ar_clear", obs(), 0);
    #1 RST = 1'b1;
    @(negedge CLK);
    bus.REQ1 = 1;
    tick(); chk("ar_regrant", {bus.GNT0, bus.GNT1, bus.OWNER}, 3'b011);
    bus.REQ1 = 0;
    tick(); tick();
    bus.ACK1 = 1;
    tick(); chk("ar_done", {bus.VLD, bus.CNT0, bus.CNT1}, {1'b0, 2'd0, 2'd1});
    bus.ACK1 = 0;

    // wrong-owner ACK for 3 cycles, then owner ACK
    bus.REQ0 = 1; bus.DIN0 = DC;
    tick(); chk("wa_gnt0", {bus.GNT0, bus.GNT1}, 2'b10);
    bus.REQ0 = 0;
    tick(); tick();
    chk("wa_vld_dout", {bus.VLD, bus.OWNER, bus.DOUT}, {2'b10, 3'b101});
    bus.ACK1 = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("wa_hold%0d", i), bus.VLD, 1);
    end
    bus.ACK1 = 0; bus.ACK0 = 1;
    tick();
    chk("wa_done", {bus.VLD, bus.TOUT, bus.CNT0}, {2'b00, 2'd1});
    bus.ACK0 = 0;

    // owner ACK sampled on the very edge the timeout expires
    bus.REQ0 = 1;
    tick(); bus.REQ0 = 0;
    tick(); tick();
    for (int i = 1; i < 15; i++) begin
      tick(); chk($sformatf("co_hold%0d", i), {bus.VLD, bus.TOUT}, 2'b10);
    end
    bus.ACK0 = 1;
    tick();
    chk("co_done", {bus.VLD, bus.TOUT, bus.BUSY, bus.CNT0}, {3'b000, 2'd2});
    bus.ACK0 = 0;
    tick(); chk("co_no_tout", bus.TOUT, 0);

    // counter wrap on a 2-bit counter: 1,2,3,0
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      bus.REQ0 = 1;
      tick(); bus.REQ0 = 0;
      tick(); tick();
      bus.ACK0 = 1;
      tick();
      chk($sformatf("wrap%0d", t), bus.CNT0, t % 4);
      bus.ACK0 = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
